// File: rtl/comb_gates_pairwise_decoder_if.sv
// -----------------------------------------------------------------------------
// comb_gates_pairwise_decoder_if
//
// Bundles the request and response handshakes of the pairwise-gate decoder.
//   Request side : in_val, in_rdy, in_seed, in_xnor, in_and, in_or
//   Response side: out_val, out_rdy, out_vec, out_err
// Modports:
//   master : the requester/consumer (drives requests, accepts results)
//   slave  : the decoder itself
// -----------------------------------------------------------------------------
interface comb_gates_pairwise_decoder_if #(
    parameter int nbits = 100
);
    logic             in_val;
    logic             in_rdy;
    logic             in_seed;
    logic [nbits-2:0] in_xnor;
    logic [nbits-2:0] in_and;
    logic [nbits-2:0] in_or;
    logic             out_val;
    logic             out_rdy;
    logic [nbits-1:0] out_vec;
    logic             out_err;

    modport master (
        output in_val, in_seed, in_xnor, in_and, in_or, out_rdy,
        input  in_rdy, out_val, out_vec, out_err
    );

    modport slave (
        input  in_val, in_seed, in_xnor, in_and, in_or, out_rdy,
        output in_rdy, out_val, out_vec, out_err
    );
endinterface

// File: rtl/comb_gates_pairwise_decoder.sv
// -----------------------------------------------------------------------------
// comb_gates_pairwise_decoder
//
// Rebuilds an nbits-wide vector from its pairwise XNOR vector and bit 0 (the
// seed), bits_per_cycle bits per cycle, while checking the supplied pairwise
// AND/OR vectors against the rebuilt bits. Any disagreement sets out_err.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : slave side of comb_gates_pairwise_decoder_if (val/rdy request in,
//           val/rdy result out)
//
// Timing: a request accepted on edge t produces out_val on edge t+C+1, where
// C = ceil((nbits-1)/bits_per_cycle). Results are held until out_rdy.
// -----------------------------------------------------------------------------
module comb_gates_pairwise_decoder #(
    parameter int nbits          = 100,
    parameter int bits_per_cycle = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    comb_gates_pairwise_decoder_if.slave  bus
);
    localparam int n_chunks = (nbits - 1 + bits_per_cycle - 1) / bits_per_cycle;
    localparam int kw       = $clog2(n_chunks + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             in_rdy_q;
    logic             out_val_q;
    logic [nbits-1:0] vec;
    logic             err;
    logic [kw-1:0]    k;

    // Operands captured at acceptance; later changes on the bus are ignored.
    logic [nbits-2:0] xnor_q;
    logic [nbits-2:0] and_q;
    logic [nbits-2:0] or_q;

    logic [nbits-1:0] vec_next;
    logic             err_next;

    // Resolve one chunk. The recurrence is chained inside the loop, so each
    // bit uses the freshly resolved bit below it within the same cycle.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        vec_next = vec;
        err_next = err;
        idx      = 0;
        for (int j = 0; j < bits_per_cycle; j++) begin
            idx = int'(k) * bits_per_cycle + j;
            if (idx < nbits - 1) begin
                vec_next[idx+1] = ~(vec_next[idx] ^ xnor_q[idx]);
                if ((and_q[idx] != (vec_next[idx] & vec_next[idx+1])) ||
                    (or_q[idx]  != (vec_next[idx] | vec_next[idx+1])))
                    err_next = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_rdy_q  <= 1'b1;
            out_val_q <= 1'b0;
            vec       <= '0;
            err       <= 1'b0;
            k         <= '0;
            // NOTE: the captured operands are not reset; they are always
            // reloaded on acceptance before being read.
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_val && in_rdy_q) begin
                        xnor_q   <= bus.in_xnor;
                        and_q    <= bus.in_and;
                        or_q     <= bus.in_or;
                        vec      <= {{(nbits-1){1'b0}}, bus.in_seed};
                        err      <= 1'b0;
                        k        <= '0;
                        in_rdy_q <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    vec <= vec_next;
                    err <= err_next;
                    // Chunks 0..n_chunks-1 resolve bits; chunk n_chunks is an
                    // empty trailing step, so the result appears on edge t+C+1.
                    if (k == kw'(n_chunks)) begin
                        out_val_q <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_rdy) begin
                        out_val_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        k         <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_rdy_q  <= 1'b1;
                    out_val_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_rdy  = in_rdy_q;
    assign bus.out_val = out_val_q;
    assign bus.out_vec = vec;
    assign bus.out_err = err;

endmodule
